fb_write_arbiter: RTL
=====================

// Module: fb_write_arbiter
// PURPOSE
// Shares the single framebuffer BRAM write port between the front-panel renderer (fire-and-forget wen/A/D)
// and the CPU data bus (four-phase req/ack). Panel writes are buffered in a small FIFO; CPU writes are
// address-decoded against a framebuffer window. Sits between the CPU/panel and the framebuf write port, clk_vga domain.
// PARAMETERS
// FIFO_DEPTH    4      panel write FIFO entries (power of two, >=2)
// STARVE_LIMIT  8      CPU wait cycles before CPU beats a non-empty FIFO
// FB_BASE       5'h1F  cpu_A[13:9] value selecting the framebuffer window (0x3E00-0x3FFF)
// PORTS
// clock      in   1   clk_vga; all logic rising-edge
// reset_n    in   1   async active-low reset
// pnl_wen    in   1   panel write strobe, one write per asserted cycle, no backpressure
// pnl_A      in   9   panel write address
// pnl_D      in   8   panel write data
// cpu_req    in   1   CPU write request, level; cpu_A/cpu_D stable while high
// cpu_A      in   14  CPU data address
// cpu_D      in   16  CPU write data; only [7:0] written
// cpu_ack    out  1   four-phase ack
// fb_wen     out  1   framebuffer write enable, registered
// fb_A       out  9   framebuffer write address, registered
// fb_D       out  8   framebuffer write data, registered
// ovf        out  1   sticky: a panel write was dropped
// fifo_level out  3   current FIFO occupancy (clog2(FIFO_DEPTH)+1 bits)
// BEHAVIOUR
// - Reset: cpu_ack=0, fb_wen=0, fb_A=0, fb_D=0, ovf=0, FIFO empty, starve counter=0, CPU FSM C_IDLE.
// - Reset mid-operation discards FIFO contents and any pending CPU write; CPU must drop and re-raise req.
// - FIFO push on pnl_wen. Push+pop same cycle legal at any level incl. full (level unchanged).
//   Push while full without pop: write dropped, ovf<=1 (cleared only by reset).
// - Grant (one per cycle): CPU if C_WAIT and (FIFO empty or starve==STARVE_LIMIT); else FIFO head if non-empty; else none.
// - Granted write appears on fb_wen/fb_A/fb_D the next cycle, asserted for exactly one cycle; fb_wen=0 when no grant.
//   fb_A/fb_D hold last value when fb_wen=0.
// - CPU FSM:
//   C_IDLE: cpu_req=1 -> C_WAIT if cpu_A[13:9]==FB_BASE, else C_ACK (no write, out-of-window ignored).
//   C_WAIT: counts starve++ (saturating at STARVE_LIMIT) each non-granted cycle; on grant -> C_ACK, starve<=0.
//   C_ACK:  cpu_ack=1 (registered, rises the cycle after grant, same cycle as fb_wen); cpu_req=0 -> C_IDLE.
//   cpu_ack=0 in C_IDLE/C_WAIT. cpu_req dropping in C_WAIT is a protocol error: return to C_IDLE, no write.
// - Minimum CPU round trip: req high cycle 0, ack high cycle 2 (empty FIFO).
// - Pointers wrap modulo FIFO_DEPTH; level width holds FIFO_DEPTH exactly.
// CONFIGURATION
// FBARB_STATS_EN defined: adds outputs stat_cpu_wr (16, count of CPU framebuffer writes) and
//   stat_drops (8, dropped panel writes); both saturate, reset to 0.
// Undefined: ports and counters absent; all other behaviour identical.
// STRUCTURE
// Package fb_arb_pkg: FB_AW=9, FB_DW=8, CPU_AW=14, CPU FSM state typedef (C_IDLE, C_WAIT, C_ACK).
// Sub-module fb_wr_fifo: parameterised sync FIFO (push/pop/full/empty/level), reused for panel buffer.
// Top contains grant logic, starve counter, CPU FSM, output registers.
// TESTING
// 1 Panel only: pnl_wen 3 cycles A=1,2,3 D=A1,A2,A3 -> fb_wen pulses A=1,2,3 in order, 1-cycle latency each.
// 2 CPU only: cpu_req, cpu_A=0x3E05, cpu_D=0x12AB -> fb_wen A=5 D=0xAB, cpu_ack=1 at cycle 2, low after req drops.
// 3 Out of window: cpu_A=0x0100 -> cpu_ack=1 at cycle 1, fb_wen never asserts.
// 4 Starvation: panel writes every cycle, CPU req -> CPU write issued after exactly STARVE_LIMIT=8 wait cycles.
// 5 Overflow: FIFO full (4), CPU held granted, one more pnl_wen -> ovf=1, fifo_level stays 4, entry lost.
// 6 Reset in C_WAIT with FIFO=3 -> all outputs reset values, fifo_level=0, no fb_wen after release.

Source files
------------

// File: rtl/fb_arb_pkg.sv
// -----------------------------------------------------------------------------
// fb_arb_pkg
// Shared widths, CPU handshake FSM state type and the buffered panel write
// record for the framebuffer write arbiter.
// No ports (package).
// -----------------------------------------------------------------------------
package fb_arb_pkg;

    localparam int FB_AW       = 9;              // framebuffer write address width
    localparam int FB_DW       = 8;              // framebuffer write data width
    localparam int CPU_AW      = 14;             // CPU data address width
    localparam int CPU_DW      = 16;             // CPU data bus width
    localparam int WIN_W       = CPU_AW - FB_AW; // window-select bits cpu_A[13:9]
    localparam int STAT_CPU_W  = 16;
    localparam int STAT_DROP_W = 8;

    typedef enum logic [1:0] {
        C_IDLE = 2'd0,
        C_WAIT = 2'd1,
        C_ACK  = 2'd2
    } cpu_state_t;

    // One buffered panel write; address in the upper bits, data in the lower.
    typedef struct packed {
        logic [FB_AW-1:0] a;
        logic [FB_DW-1:0] d;
    } fb_wr_t;

    // True when the CPU address falls inside the framebuffer window.
    function automatic logic in_fb_window(input logic [CPU_AW-1:0] addr,
                                          input logic [WIN_W-1:0]  base);
        return addr[CPU_AW-1 -: WIN_W] == base;
    endfunction

endpackage

// File: rtl/fb_wr_fifo.sv
// -----------------------------------------------------------------------------
// fb_wr_fifo
// Synchronous FIFO with occupancy output. A push into a full FIFO is accepted
// only when a pop happens in the same cycle; otherwise it is silently dropped
// (the owner detects and reports that case). Pops of an empty FIFO are ignored.
// Ports:
//   i_clk    in   1          clock, rising edge
//   i_rst_n  in   1          async active-low reset (pointers and level only)
//   i_push   in   1          write i_din this cycle
//   i_din    in   WIDTH      write data
//   i_pop    in   1          consume the head entry this cycle
//   o_dout   out  WIDTH      head entry (valid while !o_empty)
//   o_full   out  1          DEPTH entries held
//   o_empty  out  1          no entries held
//   o_level  out  clog2+1    current occupancy, 0..DEPTH
// DEPTH must be a power of two (>= 2) so the pointers wrap naturally.
// -----------------------------------------------------------------------------
module fb_wr_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_din,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_dout,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_level
);

    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [PW:0]      r_level;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_empty   = (r_level == '0);
    assign o_full    = (r_level == (PW+1)'(DEPTH));
    assign o_level   = r_level;
    assign o_dout    = r_mem[r_rd_ptr];

    assign w_do_pop  = i_pop && !o_empty;
    // At full, the slot being written is the one being read this cycle; the
    // read returns the old contents, so push+pop at full is safe.
    assign w_do_push = i_push && (!o_full || w_do_pop);

    // NOTE: storage is deliberately left out of reset -- the pointers and level
    // define which entries are valid, and a reset-free array maps onto RAM.
    always_ff @(posedge i_clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_din;
        end
    end

    // NOTE: every register is updated with <= so all flops sample the values
    // from before the edge, independent of statement order.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

endmodule

// File: rtl/fb_write_arbiter.sv
// -----------------------------------------------------------------------------
// fb_write_arbiter
// Shares the single framebuffer BRAM write port between the front-panel
// renderer (fire-and-forget, buffered in a small FIFO) and the CPU data bus
// (four-phase req/ack, decoded against the framebuffer window). clk_vga domain.
// Optional build macro: FBARB_STATS_EN adds saturating statistics outputs.
// Ports:
//   clock       in   1    clk_vga, rising edge
//   reset_n     in   1    async active-low reset
//   pnl_wen     in   1    panel write strobe, no backpressure
//   pnl_A       in   9    panel write address
//   pnl_D       in   8    panel write data
//   cpu_req     in   1    CPU write request (level); cpu_A/cpu_D stable while high
//   cpu_A       in   14   CPU address; [13:9] selects the framebuffer window
//   cpu_D       in   16   CPU write data; only [7:0] is written
//   cpu_ack     out  1    four-phase acknowledge, registered
//   fb_wen      out  1    framebuffer write enable, one-cycle pulse per write
//   fb_A        out  9    framebuffer write address, holds when fb_wen=0
//   fb_D        out  8    framebuffer write data, holds when fb_wen=0
//   ovf         out  1    sticky: a panel write was dropped
//   fifo_level  out  3    panel FIFO occupancy
//   stat_cpu_wr out  16   (FBARB_STATS_EN) CPU framebuffer writes, saturating
//   stat_drops  out  8    (FBARB_STATS_EN) dropped panel writes, saturating
// -----------------------------------------------------------------------------
module fb_write_arbiter
    import fb_arb_pkg::*;
#(
    parameter int               FIFO_DEPTH   = 4,
    parameter int               STARVE_LIMIT = 8,
    parameter logic [WIN_W-1:0] FB_BASE      = 5'h1F
) (
    input  logic                          clock,
    input  logic                          reset_n,
    input  logic                          pnl_wen,
    input  logic [FB_AW-1:0]              pnl_A,
    input  logic [FB_DW-1:0]              pnl_D,
    input  logic                          cpu_req,
    input  logic [CPU_AW-1:0]             cpu_A,
    input  logic [CPU_DW-1:0]             cpu_D,
    output logic                          cpu_ack,
    output logic                          fb_wen,
    output logic [FB_AW-1:0]              fb_A,
    output logic [FB_DW-1:0]              fb_D,
    output logic                          ovf,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
`ifdef FBARB_STATS_EN
    ,
    output logic [STAT_CPU_W-1:0]         stat_cpu_wr,
    output logic [STAT_DROP_W-1:0]        stat_drops
`endif
);

    localparam int STV_W = $clog2(STARVE_LIMIT + 1);

    cpu_state_t       r_state;
    cpu_state_t       w_state_nxt;
    logic [STV_W-1:0] r_starve;
    logic             r_cpu_ack;
    logic             r_fb_wen;
    logic [FB_AW-1:0] r_fb_a;
    logic [FB_DW-1:0] r_fb_d;
    logic             r_ovf;

    fb_wr_t           w_pnl_wr;
    fb_wr_t           w_head;
    logic             w_fifo_full;
    logic             w_fifo_empty;
    logic             w_in_window;
    logic             w_cpu_waiting;
    logic             w_starved;
    logic             w_grant_cpu;
    logic             w_grant_pnl;
    logic             w_drop;
    logic             w_unused_cpu_d_hi;

    // Upper CPU data byte is never written to the 8-bit framebuffer.
    assign w_unused_cpu_d_hi = &{1'b0, cpu_D[CPU_DW-1:FB_DW]};

    assign w_pnl_wr = '{a: pnl_A, d: pnl_D};

    fb_wr_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH ($bits(fb_wr_t))
    ) u_pnl_fifo (
        .i_clk   (clock),
        .i_rst_n (reset_n),
        .i_push  (pnl_wen),
        .i_din   (w_pnl_wr),
        .i_pop   (w_grant_pnl),
        .o_dout  (w_head),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty),
        .o_level (fifo_level)
    );

    // ---------------- grant ----------------
    // A request that drops while waiting is abandoned, so the CPU only
    // competes while cpu_req is still high.
    assign w_in_window   = in_fb_window(cpu_A, FB_BASE);
    assign w_cpu_waiting = (r_state == C_WAIT) && cpu_req;
    assign w_starved     = (r_starve == STV_W'(STARVE_LIMIT));
    assign w_grant_cpu   = w_cpu_waiting && (w_fifo_empty || w_starved);
    assign w_grant_pnl   = !w_grant_cpu && !w_fifo_empty;
    // Full with no pop this cycle: the incoming panel write is lost.
    assign w_drop        = pnl_wen && w_fifo_full && !w_grant_pnl;

    // ---------------- CPU FSM ----------------
    // NOTE: next-state is assigned a default before the case so every path
    // drives it and no latch is inferred.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            C_IDLE: if (cpu_req) w_state_nxt = w_in_window ? C_WAIT : C_ACK;
            C_WAIT: begin
                if (!cpu_req)        w_state_nxt = C_IDLE;
                else if (w_grant_cpu) w_state_nxt = C_ACK;
            end
            C_ACK:  if (!cpu_req) w_state_nxt = C_IDLE;
            default: w_state_nxt = C_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= C_IDLE;
            r_cpu_ack <= 1'b0;
            r_starve  <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_cpu_ack <= (w_state_nxt == C_ACK);
            // Counts only cycles spent waiting without a grant; any grant or
            // exit from C_WAIT starts the next request from zero.
            if (w_cpu_waiting && !w_grant_cpu) begin
                if (!w_starved) r_starve <= r_starve + 1'b1;
            end else begin
                r_starve <= '0;
            end
        end
    end

    // ---------------- write port and overflow ----------------
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_fb_wen <= 1'b0;
            r_fb_a   <= '0;
            r_fb_d   <= '0;
            r_ovf    <= 1'b0;
        end else begin
            r_fb_wen <= w_grant_cpu || w_grant_pnl;
            if (w_grant_cpu) begin
                r_fb_a <= cpu_A[FB_AW-1:0];
                r_fb_d <= cpu_D[FB_DW-1:0];
            end else if (w_grant_pnl) begin
                r_fb_a <= w_head.a;
                r_fb_d <= w_head.d;
            end
            if (w_drop) r_ovf <= 1'b1;
        end
    end

    assign cpu_ack = r_cpu_ack;
    assign fb_wen  = r_fb_wen;
    assign fb_A    = r_fb_a;
    assign fb_D    = r_fb_d;
    assign ovf     = r_ovf;

`ifdef FBARB_STATS_EN
    logic [STAT_CPU_W-1:0]  r_stat_cpu_wr;
    logic [STAT_DROP_W-1:0] r_stat_drops;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_stat_cpu_wr <= '0;
            r_stat_drops  <= '0;
        end else begin
            if (w_grant_cpu && (r_stat_cpu_wr != '1)) r_stat_cpu_wr <= r_stat_cpu_wr + 1'b1;
            if (w_drop && (r_stat_drops != '1))       r_stat_drops  <= r_stat_drops + 1'b1;
        end
    end

    assign stat_cpu_wr = r_stat_cpu_wr;
    assign stat_drops  = r_stat_drops;
`endif

endmodule
